// File: rtl/uart_rx_gen_if.sv
// Receive-side word handshake of uart_rx_gen: the word, its qualifying flags and the
// consumer's accept. master = receiver, slave = consumer.
interface uart_rx_gen_if #(
   parameter int DATA_BITS = 8
);
   logic [DATA_BITS-1:0] d_out;
   logic                 rx_valid;
   logic                 rx_ready;
   logic                 parity_err;
   logic                 frame_err;
   logic                 overrun;

   modport master (output d_out, rx_valid, parity_err, frame_err, overrun, input rx_ready);
   modport slave  (input d_out, rx_valid, parity_err, frame_err, overrun, output rx_ready);
endinterface

// File: rtl/uart_rx_gen.sv
// Oversampled UART receiver with run-time parity/stop configuration and a valid/ready word port.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around every sample point.
module uart_rx_gen #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          tick,
   input  logic          rx,
   input  logic          parity_en,
   input  logic          parity_odd,
   input  logic          stop2,
   uart_rx_gen_if.master bus
);
   localparam int CW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t               state_q, state_d;
   logic [1:0]           sync;
   logic                 rx_s, sample, at_pt, done;
   logic [CW-1:0]        cnt;
   logic [BW-1:0]        bit_cnt;
   logic [DATA_BITS-1:0] sh;
   logic                 par_en_q, par_odd_q, stop2_q, stop_cnt, pe_acc, fe_acc;

   assign rx_s = sync[1];

`ifdef RX_MAJORITY_VOTE_EN
   // Decision is taken one tick past mid-bit so the three votes are mid-1, mid, mid+1.
   localparam int START_PT = OVERSAMPLE / 2 + 1;
   logic [1:0] hist;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)    hist <= 2'b11;
      else if (tick) hist <= {hist[0], rx_s};
   end

   assign sample = (hist[1] & hist[0]) | (rx_s & (hist[1] | hist[0]));
`else
   localparam int START_PT = OVERSAMPLE / 2;
   assign sample = rx_s;
`endif

   assign at_pt = tick && ((state_q == START) ? (cnt == CW'(START_PT - 1))
                                              : (cnt == CW'(OVERSAMPLE - 1)));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync    <= 2'b11;
         state_q <= IDLE;
      end else begin
         sync    <= {sync[0], rx};
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      done    = 1'b0;
      if (tick) begin
         case (state_q)
            IDLE:   if (!rx_s) state_d = START;
            START:  if (at_pt) state_d = sample ? IDLE : DATA;
            DATA:   if (at_pt && bit_cnt == BW'(DATA_BITS - 1)) state_d = par_en_q ? PARITY : STOP;
            PARITY: if (at_pt) state_d = STOP;
            STOP:   if (at_pt && (!stop2_q || stop_cnt)) begin
               state_d = IDLE;
               done    = 1'b1;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt            <= '0;
         bit_cnt        <= '0;
         sh             <= '0;
         par_en_q       <= 1'b0;
         par_odd_q      <= 1'b0;
         stop2_q        <= 1'b0;
         stop_cnt       <= 1'b0;
         pe_acc         <= 1'b0;
         fe_acc         <= 1'b0;
         bus.d_out      <= '0;
         bus.rx_valid   <= 1'b0;
         bus.parity_err <= 1'b0;
         bus.frame_err  <= 1'b0;
         bus.overrun    <= 1'b0;
      end else begin
         if (tick) cnt <= (state_q == IDLE || at_pt) ? '0 : cnt + 1'b1;

         // Frame configuration is frozen at the start edge.
         if (tick && state_q == IDLE && !rx_s) begin
            par_en_q  <= parity_en;
            par_odd_q <= parity_odd;
            stop2_q   <= stop2;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            pe_acc    <= 1'b0;
            fe_acc    <= 1'b0;
         end

         if (at_pt) begin
            case (state_q)
               DATA: begin
                  sh      <= {sample, sh[DATA_BITS-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: pe_acc <= ((^sh) ^ sample) != par_odd_q;
               STOP: begin
                  fe_acc   <= fe_acc | ~sample;
                  stop_cnt <= 1'b1;
               end
               default: ;
            endcase
         end

         // A completion wins over acceptance; overrun only if the old word was left unread.
         if (done) begin
            bus.d_out      <= sh;
            bus.parity_err <= pe_acc;
            bus.frame_err  <= fe_acc | ~sample;
            bus.rx_valid   <= 1'b1;
            bus.overrun    <= bus.rx_valid & ~bus.rx_ready;
         end else if (bus.rx_valid && bus.rx_ready) begin
            bus.rx_valid <= 1'b0;
            bus.overrun  <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_uart_rx_gen.sv
// Self-checking bench for uart_rx_gen: directed vector table, randomized frames against a
// frame-level reference model, and hand sequences for false start, overrun and reset.
module tb_uart_rx_gen;
   localparam int DB = 8, OS = 16, TDIV = 4, BITCLK = OS * TDIV;

   typedef struct packed {
      logic [DB-1:0] d;
      logic          pe;
      logic          fe;
   } word_t;

   typedef struct {
      logic [DB-1:0] data;
      bit            pen, odd, s2, pbit, sa, sb;
      logic [DB-1:0] ed;
      bit            epe, efe;
   } vec_t;

   logic clk = 1'b0, reset = 1'b0, tick = 1'b0, rx = 1'b1;
   logic parity_en = 1'b0, parity_odd = 1'b0, stop2 = 1'b0;
   int   div = 0;
   int   checks = 0, errors = 0;
   int   vrun = 0, last_w = 0, valid_seen = 0;
   word_t cap[$];

   uart_rx_gen_if #(.DATA_BITS(DB)) bus ();

   uart_rx_gen #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .rx(rx), .parity_en(parity_en),
      .parity_odd(parity_odd), .stop2(stop2), .bus(bus.master)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      div  <= (div == TDIV - 1) ? 0 : div + 1;
      tick <= (div == TDIV - 1);
   end

   // Records every accepted word and the width of each rx_valid run.
   always @(negedge clk) begin
      if (bus.rx_valid) begin
         vrun++;
         valid_seen++;
         if (bus.rx_ready) cap.push_back({bus.d_out, bus.parity_err, bus.frame_err});
      end else if (vrun != 0) begin
         last_w = vrun;
         vrun   = 0;
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic word_t model(input logic [DB-1:0] data, input bit pen, input bit odd,
                                   input bit pbit, input bit s2, input bit sa, input bit sb);
      word_t w;
      int    ones;
      ones = $countones(data);
      w.d  = data;
      w.pe = pen && (((ones + int'(pbit)) % 2) != int'(odd));
      w.fe = !sa || (s2 && !sb);
      return w;
   endfunction

   task automatic drive(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v, input bit gl);
      if (gl) begin
         drive(v, BITCLK / 2);
         drive(~v, TDIV);
         drive(v, BITCLK / 2 - TDIV);
      end else begin
         drive(v, BITCLK);
      end
   endtask

   // Sends one frame, then a bit time of idle; config inputs are scrambled after the start bit.
   task automatic send_frame(input logic [DB-1:0] data, input bit pen, input bit odd, input bit s2,
                             input bit pbit, input bit sa, input bit sb, input int glitch);
      parity_en  = pen;
      parity_odd = odd;
      stop2      = s2;
      drive(1'b0, BITCLK);
      parity_en  = 1'($urandom);
      parity_odd = 1'($urandom);
      stop2      = 1'($urandom);
      for (int i = 0; i < DB; i++) drive_bit(data[i], glitch == i);
      if (pen) drive(pbit, BITCLK);
      drive(sa, BITCLK);
      if (s2) drive(sb, BITCLK);
      drive(1'b1, BITCLK);
   endtask

   task automatic check_word(input string nm, input word_t e);
      word_t w;
      if (cap.size() == 0) begin
         chk({nm, "_present"}, 32'd0, 32'd1);
      end else begin
         w = cap.pop_front();
         chk({nm, "_data"}, 32'(w.d), 32'(e.d));
         chk({nm, "_perr"}, 32'(w.pe), 32'(e.pe));
         chk({nm, "_ferr"}, 32'(w.fe), 32'(e.fe));
      end
   endtask

   task automatic set_ready(input logic v);
      @(posedge clk);
      #1 bus.rx_ready = v;
   endtask

   initial begin
      vec_t  vt[10];
      word_t e;
      int    seen0;
      logic [DB-1:0] d;
      bit pen, odd, s2, pbit, sa, sb;

      vt[0] = '{8'hA5, 0, 0, 0, 0, 1, 1, 8'hA5, 0, 0};
      vt[1] = '{8'h3C, 1, 0, 0, 1, 1, 1, 8'h3C, 1, 0};
      vt[2] = '{8'h3C, 1, 1, 0, 1, 1, 1, 8'h3C, 0, 0};
      vt[3] = '{8'h55, 0, 0, 1, 0, 1, 0, 8'h55, 0, 1};
      vt[4] = '{8'h00, 0, 0, 0, 0, 0, 1, 8'h00, 0, 1};
      vt[5] = '{8'hFF, 1, 0, 0, 0, 1, 1, 8'hFF, 0, 0};
      vt[6] = '{8'h01, 1, 1, 0, 0, 1, 1, 8'h01, 0, 0};
      vt[7] = '{8'h80, 1, 0, 1, 1, 1, 1, 8'h80, 0, 0};
      vt[8] = '{8'hC3, 1, 1, 1, 1, 0, 1, 8'hC3, 0, 1};
      vt[9] = '{8'h7E, 1, 0, 0, 1, 1, 1, 8'h7E, 1, 0};

      bus.rx_ready = 1'b1;
      repeat (5) @(negedge clk);
      chk("rst_d_out", 32'(bus.d_out), 32'd0);
      chk("rst_valid", 32'(bus.rx_valid), 32'd0);
      chk("rst_perr", 32'(bus.parity_err), 32'd0);
      chk("rst_ferr", 32'(bus.frame_err), 32'd0);
      chk("rst_overrun", 32'(bus.overrun), 32'd0);
      reset = 1'b1;
      drive(1'b1, BITCLK);

      for (int i = 0; i < 10; i++) begin
         last_w = 0;
         send_frame(vt[i].data, vt[i].pen, vt[i].odd, vt[i].s2, vt[i].pbit, vt[i].sa, vt[i].sb, -1);
         check_word($sformatf("vec%0d", i), {vt[i].ed, vt[i].epe, vt[i].efe});
         chk($sformatf("vec%0d_pulse", i), 32'(last_w), 32'd1);
      end

      for (int i = 0; i < 30; i++) begin
         d    = DB'($urandom);
         pen  = 1'($urandom);
         odd  = 1'($urandom);
         s2   = 1'($urandom);
         pbit = 1'($urandom);
         sa   = ($urandom_range(3) != 0);
         sb   = ($urandom_range(3) != 0);
         e    = model(d, pen, odd, pbit, s2, sa, sb);
         send_frame(d, pen, odd, s2, pbit, sa, sb, -1);
         check_word($sformatf("rnd%0d", i), e);
      end

      // Start pulse too short to survive the mid-bit check.
      seen0 = valid_seen;
      drive(1'b0, (OS / 2 - 2) * TDIV);
      drive(1'b1, 2 * BITCLK);
      chk("false_start_no_valid", 32'(valid_seen - seen0), 32'd0);
      send_frame(8'h5A, 0, 0, 0, 0, 1, 1, -1);
      check_word("after_false_start", {8'h5A, 1'b0, 1'b0});

      set_ready(1'b0);
      send_frame(8'h11, 0, 0, 0, 0, 1, 1, -1);
      chk("ovr_first_valid", 32'(bus.rx_valid), 32'd1);
      chk("ovr_first_flag", 32'(bus.overrun), 32'd0);
      send_frame(8'h22, 0, 0, 0, 0, 1, 1, -1);
      chk("ovr_d_out", 32'(bus.d_out), 32'h22);
      chk("ovr_valid", 32'(bus.rx_valid), 32'd1);
      chk("ovr_flag", 32'(bus.overrun), 32'd1);
      cap.delete();
      set_ready(1'b1);
      set_ready(1'b0);
      @(negedge clk);
      chk("ovr_accept_valid", 32'(bus.rx_valid), 32'd0);
      chk("ovr_accept_flag", 32'(bus.overrun), 32'd0);
      check_word("ovr_accepted", {8'h22, 1'b0, 1'b0});

      send_frame(8'h33, 0, 0, 0, 0, 0, 1, -1);
      chk("pre_reset_valid", 32'(bus.rx_valid), 32'd1);
      drive(1'b0, BITCLK);
      drive(1'b1, BITCLK);
      drive(1'b0, BITCLK / 2);
      reset = 1'b0;
      #1;
      chk("mid_reset_d_out", 32'(bus.d_out), 32'd0);
      chk("mid_reset_valid", 32'(bus.rx_valid), 32'd0);
      chk("mid_reset_ferr", 32'(bus.frame_err), 32'd0);
      chk("mid_reset_overrun", 32'(bus.overrun), 32'd0);
      rx = 1'b1;
      repeat (4) @(negedge clk);
      reset = 1'b1;
      set_ready(1'b1);
      drive(1'b1, 2 * BITCLK);
      cap.delete();
      send_frame(8'h81, 0, 0, 0, 0, 1, 1, -1);
      check_word("post_reset", {8'h81, 1'b0, 1'b0});

`ifdef RX_MAJORITY_VOTE_EN
      send_frame(8'h81, 0, 0, 0, 0, 1, 1, 3);
      check_word("vote_glitch", {8'h81, 1'b0, 1'b0});
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
